// File: rtl/wb_commit_unit_pkg.sv
// Shared SoC write-back definitions: operation encodings, FIFO depth, commit FSM states
// and the queued-entry layout used by wb_commit_unit and wb_fifo.
package wb_commit_unit_pkg;

    localparam int unsigned RAM_OP_LEN = 2;
    localparam int unsigned SFR_OP_LEN = 3;
    localparam int unsigned WB_DEPTH   = 2;

    localparam logic [RAM_OP_LEN-1:0] OP_RAM_NOP     = 2'd0;
    localparam logic [RAM_OP_LEN-1:0] OP_RAM_WR_BYTE = 2'd1;
    localparam logic [SFR_OP_LEN-1:0] OP_DEFAULT     = 3'd0;
    localparam logic [SFR_OP_LEN-1:0] OP_ACC_WR_BYTE = 3'd1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } wb_state_e;

    typedef struct packed {
        logic [7:0]            addr;
        logic [7:0]            data;
        logic [7:0]            psw;
        logic [RAM_OP_LEN-1:0] ram_op;
        logic [SFR_OP_LEN-1:0] sfr_op;
    } wb_entry_t;

    function automatic logic is_ram(input wb_entry_t e);
        return e.ram_op != OP_RAM_NOP;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Two-entry register FIFO of pending write-backs; exposes head and the younger
// entry so the commit unit can forward from either.
module wb_fifo
    import wb_commit_unit_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_push,
    input  logic       i_pop,
    input  wb_entry_t  i_entry,
    output wb_entry_t  o_head,
    output wb_entry_t  o_tail,
    output logic [1:0] o_count
);

    wb_entry_t  r_mem [WB_DEPTH];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;
    logic       w_pop;
    logic       w_push;

    assign w_pop  = i_pop && (r_count != 2'd0);
    assign w_push = i_push && ((r_count < 2'd2) || w_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset; validity is carried by r_count.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_entry;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_tail  = r_mem[~r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/wb_commit_unit.sv
// Write-back commit unit: queues RAM/SFR writes and retires them strictly in order.
// Optional read bypass of queued RAM writes is enabled by defining WB_FORWARD_EN.
module wb_commit_unit
    import wb_commit_unit_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [7:0]            i_wr_addr,
    input  logic [7:0]            i_wr_data,
    input  logic [7:0]            i_wr_psw,
    input  logic [RAM_OP_LEN-1:0] i_ram_op,
    input  logic [SFR_OP_LEN-1:0] i_sfr_op,
    output logic                  o_ram_req,
    output logic [7:0]            o_ram_addr,
    output logic [7:0]            o_ram_data,
    input  logic                  i_ram_ack,
    output logic [SFR_OP_LEN-1:0] o_sfr_op,
    output logic [7:0]            o_sfr_data,
    output logic [7:0]            o_sfr_psw,
    input  logic [7:0]            i_fwd_addr,
    output logic                  o_fwd_hit,
    output logic [7:0]            o_fwd_data,
    output logic                  o_stall
);

    wb_entry_t  w_in;
    wb_entry_t  w_head;
    wb_entry_t  w_tail;
    logic [1:0] w_count;
    logic       w_head_vld;
    logic       w_head_ram;
    logic       w_sfr_commit;
    logic       w_ram_done;
    logic       w_pop;
    logic       w_push;
    logic       w_discard;
    wb_state_e  r_state;
    wb_state_e  w_state_nxt;

    assign w_in = '{addr: i_wr_addr, data: i_wr_data, psw: i_wr_psw,
                    ram_op: i_ram_op, sfr_op: i_sfr_op};

    assign w_discard  = (i_ram_op == OP_RAM_NOP) && (i_sfr_op == OP_DEFAULT);
    assign w_head_vld = (w_count != 2'd0);
    assign w_head_ram = w_head_vld && is_ram(w_head);
    assign w_pop      = w_sfr_commit || w_ram_done;
    assign o_ready    = (w_count < 2'd2) || w_pop;
    assign o_stall    = ~o_ready;
    assign w_push     = i_valid && o_ready && !w_discard;

    wb_fifo u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_entry (w_in),
        .o_head  (w_head),
        .o_tail  (w_tail),
        .o_count (w_count)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Request is raised combinationally from IDLE so a RAM head starts committing in the
    // cycle it arrives; an ack in that same cycle retires it without entering REQ.
    always_comb begin
        w_state_nxt  = r_state;
        w_sfr_commit = 1'b0;
        w_ram_done   = 1'b0;
        o_ram_req    = 1'b0;
        o_ram_addr   = '0;
        o_ram_data   = '0;
        o_sfr_op     = OP_DEFAULT;
        o_sfr_data   = '0;
        o_sfr_psw    = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_head_ram) begin
                    o_ram_req = 1'b1;
                    if (i_ram_ack) w_ram_done  = 1'b1;
                    else           w_state_nxt = ST_REQ;
                end else if (w_head_vld) begin
                    w_sfr_commit = 1'b1;
                end
            end
            ST_REQ: begin
                o_ram_req = 1'b1;
                if (i_ram_ack) begin
                    w_ram_done  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (o_ram_req) begin
            o_ram_addr = w_head.addr;
            o_ram_data = w_head.data;
        end
        if ((w_sfr_commit || w_ram_done) && (w_head.sfr_op != OP_DEFAULT)) begin
            o_sfr_op   = w_head.sfr_op;
            o_sfr_data = w_head.data;
            o_sfr_psw  = w_head.psw;
        end
    end

`ifdef WB_FORWARD_EN
    // Younger entry is checked last so its data wins on a double match.
    always_comb begin
        o_fwd_hit  = 1'b0;
        o_fwd_data = '0;
        if (w_head_ram && (w_head.addr == i_fwd_addr)) begin
            o_fwd_hit  = 1'b1;
            o_fwd_data = w_head.data;
        end
        if ((w_count == 2'd2) && is_ram(w_tail) && (w_tail.addr == i_fwd_addr)) begin
            o_fwd_hit  = 1'b1;
            o_fwd_data = w_tail.data;
        end
    end
`else
    logic w_fwd_unused;
    assign w_fwd_unused = ^{i_fwd_addr, w_tail};
    assign o_fwd_hit    = 1'b0;
    assign o_fwd_data   = '0;
`endif

endmodule

// File: tb/tb_wb_commit_unit.sv
// Self-checking bench for wb_commit_unit: directed vector table, reset and forwarding
// sequences, then random traffic checked against a queue-based model.
module tb_wb_commit_unit;
    import wb_commit_unit_pkg::*;

`ifdef WB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam logic [RAM_OP_LEN-1:0] RN = OP_RAM_NOP;
    localparam logic [RAM_OP_LEN-1:0] RW = OP_RAM_WR_BYTE;
    localparam logic [SFR_OP_LEN-1:0] SD = OP_DEFAULT;
    localparam logic [SFR_OP_LEN-1:0] SA = OP_ACC_WR_BYTE;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  i_valid;
    logic                  o_ready;
    logic [7:0]            i_wr_addr, i_wr_data, i_wr_psw;
    logic [RAM_OP_LEN-1:0] i_ram_op;
    logic [SFR_OP_LEN-1:0] i_sfr_op;
    logic                  o_ram_req;
    logic [7:0]            o_ram_addr, o_ram_data;
    logic                  i_ram_ack;
    logic [SFR_OP_LEN-1:0] o_sfr_op;
    logic [7:0]            o_sfr_data, o_sfr_psw;
    logic [7:0]            i_fwd_addr;
    logic                  o_fwd_hit;
    logic [7:0]            o_fwd_data;
    logic                  o_stall;

    always #5 clk = ~clk;

    wb_commit_unit dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data), .i_wr_psw(i_wr_psw),
        .i_ram_op(i_ram_op), .i_sfr_op(i_sfr_op),
        .o_ram_req(o_ram_req), .o_ram_addr(o_ram_addr), .o_ram_data(o_ram_data),
        .i_ram_ack(i_ram_ack), .o_sfr_op(o_sfr_op), .o_sfr_data(o_sfr_data),
        .o_sfr_psw(o_sfr_psw), .i_fwd_addr(i_fwd_addr), .o_fwd_hit(o_fwd_hit),
        .o_fwd_data(o_fwd_data), .o_stall(o_stall)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0]            addr, data, psw;
        logic [RAM_OP_LEN-1:0] ram;
        logic [SFR_OP_LEN-1:0] sfr;
    } ent_t;

    ent_t q[$];
    bit   m_pop, m_push;

    typedef struct {
        logic                  v;
        logic [7:0]            addr, data, psw;
        logic [RAM_OP_LEN-1:0] ram;
        logic [SFR_OP_LEN-1:0] sfr;
        logic                  ack;
        logic                  rdy, req;
        logic [7:0]            raddr, rdata;
        logic [SFR_OP_LEN-1:0] sop;
        logic [7:0]            sdata;
    } vec_t;

    vec_t tab[23];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // Expected outputs follow from the queue contents: the head commits (SFR at once,
    // RAM on ack), and the unit can take a request if it has room after that commit.
    task automatic model_check();
        ent_t       h;
        bit         hram, hsfr, rdy, fh;
        logic [7:0] fd;
        h    = '{default: '0};
        if (q.size() > 0) h = q[0];
        hram = (q.size() > 0) && (h.ram != RN);
        hsfr = (q.size() > 0) && (h.ram == RN);
        m_pop  = hsfr || (hram && i_ram_ack);
        rdy    = (q.size() < 2) || m_pop;
        m_push = i_valid && rdy && !((i_ram_op == RN) && (i_sfr_op == SD));
        fh = 1'b0;
        fd = 8'h00;
        if (FWD) begin
            foreach (q[i]) if ((q[i].ram != RN) && (q[i].addr == i_fwd_addr)) begin
                fh = 1'b1;
                fd = q[i].data;
            end
        end
        chk("m.ready",    32'(o_ready),    32'(rdy));
        chk("m.stall",    32'(o_stall),    32'(!rdy));
        chk("m.ram_req",  32'(o_ram_req),  32'(hram));
        chk("m.ram_addr", 32'(o_ram_addr), hram ? 32'(h.addr) : 32'h0);
        chk("m.ram_data", 32'(o_ram_data), hram ? 32'(h.data) : 32'h0);
        chk("m.sfr_op",   32'(o_sfr_op),   hsfr ? 32'(h.sfr) : 32'(SD));
        chk("m.sfr_data", 32'(o_sfr_data), hsfr ? 32'(h.data) : 32'h0);
        chk("m.sfr_psw",  32'(o_sfr_psw),  hsfr ? 32'(h.psw) : 32'h0);
        chk("m.fwd_hit",  32'(o_fwd_hit),  32'(fh));
        chk("m.fwd_data", 32'(o_fwd_data), 32'(fd));
    endtask

    task automatic cyc_begin(input logic v, input logic [7:0] a, input logic [7:0] d,
                             input logic [7:0] p, input logic [RAM_OP_LEN-1:0] r,
                             input logic [SFR_OP_LEN-1:0] s, input logic ack,
                             input logic [7:0] fa);
        i_valid = v; i_wr_addr = a; i_wr_data = d; i_wr_psw = p;
        i_ram_op = r; i_sfr_op = s; i_ram_ack = ack; i_fwd_addr = fa;
        @(negedge clk);
        model_check();
    endtask

    task automatic cyc_end();
        ent_t e;
        @(posedge clk);
        e = '{addr: i_wr_addr, data: i_wr_data, psw: i_wr_psw, ram: i_ram_op, sfr: i_sfr_op};
        if (m_pop)  void'(q.pop_front());
        if (m_push) q.push_back(e);
        #1;
    endtask

    function automatic vec_t mk(input logic v, input logic [7:0] a, input logic [7:0] d,
                                input logic [7:0] p, input logic [RAM_OP_LEN-1:0] r,
                                input logic [SFR_OP_LEN-1:0] s, input logic ack,
                                input logic rdy, input logic req, input logic [7:0] ra,
                                input logic [7:0] rd, input logic [SFR_OP_LEN-1:0] so,
                                input logic [7:0] sd);
        return '{v, a, d, p, r, s, ack, rdy, req, ra, rd, so, sd};
    endfunction

    initial begin
        // SFR pulse, RAM stall with ordering, full/simultaneous push-pop, discard, 3-deep fill
        tab[0]  = mk(1, 8'h00, 8'h5A, 8'h81, RN, SA, 0,  1, 0, 8'h00, 8'h00, SD, 8'h00);
        tab[1]  = mk(0, 8'h00, 8'h00, 8'h00, RN, SD, 0,  1, 0, 8'h00, 8'h00, SA, 8'h5A);
        tab[2]  = mk(0, 8'h00, 8'h00, 8'h00, RN, SD, 0,  1, 0, 8'h00, 8'h00, SD, 8'h00);
        tab[3]  = mk(1, 8'h30, 8'h11, 8'h00, RW, SD, 0,  1, 0, 8'h00, 8'h00, SD, 8'h00);
        for (int i = 4; i <= 8; i++)
            tab[i] = mk(0, 8'h00, 8'h00, 8'h00, RN, SD, 0,  1, 1, 8'h30, 8'h11, SD, 8'h00);
        tab[9]  = mk(1, 8'h00, 8'h77, 8'h00, RN, SA, 0,  1, 1, 8'h30, 8'h11, SD, 8'h00);
        tab[10] = mk(0, 8'h00, 8'h00, 8'h00, RN, SD, 0,  0, 1, 8'h30, 8'h11, SD, 8'h00);
        tab[11] = mk(1, 8'h31, 8'h22, 8'h00, RW, SD, 0,  0, 1, 8'h30, 8'h11, SD, 8'h00);
        tab[12] = mk(1, 8'h31, 8'h22, 8'h00, RW, SD, 1,  1, 1, 8'h30, 8'h11, SD, 8'h00);
        tab[13] = mk(0, 8'h00, 8'h00, 8'h00, RN, SD, 1,  1, 0, 8'h00, 8'h00, SA, 8'h77);
        tab[14] = mk(0, 8'h00, 8'h00, 8'h00, RN, SD, 1,  1, 1, 8'h31, 8'h22, SD, 8'h00);
        tab[15] = mk(0, 8'h00, 8'h00, 8'h00, RN, SD, 0,  1, 0, 8'h00, 8'h00, SD, 8'h00);
        tab[16] = mk(1, 8'h00, 8'h99, 8'h00, RN, SD, 0,  1, 0, 8'h00, 8'h00, SD, 8'h00);
        tab[17] = mk(0, 8'h00, 8'h00, 8'h00, RN, SD, 1,  1, 0, 8'h00, 8'h00, SD, 8'h00);
        tab[18] = mk(1, 8'h50, 8'hA1, 8'h00, RW, SD, 0,  1, 0, 8'h00, 8'h00, SD, 8'h00);
        tab[19] = mk(1, 8'h51, 8'hA2, 8'h00, RW, SD, 0,  1, 1, 8'h50, 8'hA1, SD, 8'h00);
        tab[20] = mk(1, 8'h00, 8'hC3, 8'h00, RN, SA, 0,  0, 1, 8'h50, 8'hA1, SD, 8'h00);
        tab[21] = mk(1, 8'h00, 8'hC3, 8'h00, RN, SA, 1,  1, 1, 8'h50, 8'hA1, SD, 8'h00);
        tab[22] = mk(0, 8'h00, 8'h00, 8'h00, RN, SD, 0,  0, 1, 8'h51, 8'hA2, SD, 8'h00);

        rst_n = 1'b0;
        i_valid = 0; i_wr_addr = '0; i_wr_data = '0; i_wr_psw = '0;
        i_ram_op = RN; i_sfr_op = SD; i_ram_ack = 0; i_fwd_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.ready",    32'(o_ready),    32'h1);
        chk("rst.stall",    32'(o_stall),    32'h0);
        chk("rst.ram_req",  32'(o_ram_req),  32'h0);
        chk("rst.ram_addr", 32'(o_ram_addr), 32'h0);
        chk("rst.ram_data", 32'(o_ram_data), 32'h0);
        chk("rst.sfr_op",   32'(o_sfr_op),   32'(SD));
        chk("rst.sfr_data", 32'(o_sfr_data), 32'h0);
        chk("rst.sfr_psw",  32'(o_sfr_psw),  32'h0);
        chk("rst.fwd_hit",  32'(o_fwd_hit),  32'h0);
        chk("rst.fwd_data", 32'(o_fwd_data), 32'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tab[i]) begin
            cyc_begin(tab[i].v, tab[i].addr, tab[i].data, tab[i].psw, tab[i].ram,
                      tab[i].sfr, tab[i].ack, 8'h00);
            chk($sformatf("tab%0d.ready", i),    32'(o_ready),    32'(tab[i].rdy));
            chk($sformatf("tab%0d.ram_req", i),  32'(o_ram_req),  32'(tab[i].req));
            chk($sformatf("tab%0d.ram_addr", i), 32'(o_ram_addr), 32'(tab[i].raddr));
            chk($sformatf("tab%0d.ram_data", i), 32'(o_ram_data), 32'(tab[i].rdata));
            chk($sformatf("tab%0d.sfr_op", i),   32'(o_sfr_op),   32'(tab[i].sop));
            chk($sformatf("tab%0d.sfr_data", i), 32'(o_sfr_data), 32'(tab[i].sdata));
            cyc_end();
        end

        // Reset while a RAM request is outstanding with a second entry queued behind it
        #2 rst_n = 1'b0;
        #1;
        chk("midrst.ram_req", 32'(o_ram_req), 32'h0);
        chk("midrst.ready",   32'(o_ready),   32'h1);
        chk("midrst.sfr_op",  32'(o_sfr_op),  32'(SD));
        q.delete();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            cyc_begin(0, 8'h00, 8'h00, 8'h00, RN, SD, 0, 8'h00);
            chk("postrst.sfr_op",  32'(o_sfr_op),  32'(SD));
            chk("postrst.ram_req", 32'(o_ram_req), 32'h0);
            cyc_end();
        end

        // Forwarding: two queued writes to the same address, youngest data wins
        cyc_begin(1, 8'h40, 8'h01, 8'h00, RW, SD, 0, 8'h40);
        cyc_end();
        cyc_begin(1, 8'h40, 8'h02, 8'h00, RW, SD, 0, 8'h40);
        chk("fwd1.hit",  32'(o_fwd_hit),  FWD ? 32'h1 : 32'h0);
        chk("fwd1.data", 32'(o_fwd_data), FWD ? 32'h01 : 32'h0);
        cyc_end();
        cyc_begin(0, 8'h00, 8'h00, 8'h00, RN, SD, 0, 8'h40);
        chk("fwd2.hit",  32'(o_fwd_hit),  FWD ? 32'h1 : 32'h0);
        chk("fwd2.data", 32'(o_fwd_data), FWD ? 32'h02 : 32'h0);
        cyc_end();
        for (int i = 0; i < 3; i++) begin
            cyc_begin(0, 8'h00, 8'h00, 8'h00, RN, SD, 1, 8'h40);
            cyc_end();
        end

        for (int n = 0; n < 400; n++) begin
            int unsigned op;
            logic [RAM_OP_LEN-1:0] r;
            logic [SFR_OP_LEN-1:0] s;
            op = $urandom_range(0, 3);
            r  = (op >= 2) ? RW : RN;
            s  = (op == 1) ? SFR_OP_LEN'($urandom_range(1, 7)) : SD;
            cyc_begin($urandom_range(0, 3) != 0, 8'(8'h40 + $urandom_range(0, 3)),
                      8'($urandom), 8'($urandom), r, s, 1'($urandom_range(0, 1)),
                      8'(8'h40 + $urandom_range(0, 3)));
            cyc_end();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
